load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32 load/store unit: a multi-cycle FSM that bridges byte/half/word requests
// to a word-wide data memory with sign/zero extension and read-modify-write stores.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_misaligned,
  output logic                  rsp_illegal,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  cs_mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_next;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        write_q;
  logic        illegal_in;
  logic        misaligned_in;

  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] word,
    input logic [2:0]            f3,
    input logic [1:0]            lane
  );
    logic        [7:0]            b;
    logic        [15:0]           h;
    logic signed [7:0]            bs;
    logic signed [15:0]           hs;
    logic signed [DATA_WIDTH-1:0] r;
    b  = word[{lane, 3'b000} +: 8];
    h  = word[{lane[1], 4'b0000} +: 16];
    bs = b;
    hs = h;
    case (f3)
      3'b000:  r = DATA_WIDTH'(bs);
      3'b001:  r = DATA_WIDTH'(hs);
      3'b100:  r = $signed({{(DATA_WIDTH-8){1'b0}}, b});
      3'b101:  r = $signed({{(DATA_WIDTH-16){1'b0}}, h});
      default: r = $signed(word);
    endcase
    return $unsigned(r);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] word,
    input logic [15:0]           wdata,
    input logic [1:0]            f3,
    input logic [1:0]            lane
  );
    logic [DATA_WIDTH-1:0] r;
    r = word;
    case (f3)
      2'b00:   r[{lane, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata;
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    illegal_in = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal_in = 1'b0;
      3'b100, 3'b101:         illegal_in = req_is_store;
      default:                illegal_in = 1'b1;
    endcase
  end

  always_comb begin
    misaligned_in = 1'b0;
    if (req_funct3[1:0] == 2'b01)
      misaligned_in = req_addr[0];
    else if (req_funct3[1:0] == 2'b10)
      misaligned_in = (req_addr[1:0] != 2'b00);
  end

  assign req_ready = (state == IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegal_in || misaligned_in) state_next = RESP;
          else if (!req_is_store)          state_next = READ;
          else if (req_funct3 == 3'b010)   state_next = WRITE;
          else                             state_next = READ;
        end
      end
      READ:    state_next = is_store_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A reset edge must not see a write enable left over from WRITE.
  assign cs_mem_write = write_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_misaligned <= 1'b0;
      rsp_illegal    <= 1'b0;
      write_q        <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      state          <= state_next;
      rsp_valid      <= (state_next == RESP);
      write_q        <= (state_next == WRITE);
      rsp_rdata      <= '0;
      rsp_misaligned <= 1'b0;
      rsp_illegal    <= 1'b0;
      case (state)
        // Accept: latch the request and decode faults straight into RESP.
        IDLE: begin
          if (req_valid) begin
            mem_addr       <= {2'b00, req_addr[ADDR_WIDTH-1:2]};
            mem_write_data <= req_wdata;
            rsp_illegal    <= illegal_in;
            rsp_misaligned <= misaligned_in & ~illegal_in;
          end
        end
        // Read: capture the load result or merge the sub-word store.
        READ: begin
          if (is_store_q)
            mem_write_data <= store_merge(mem_read_data, wdata_q, funct3_q[1:0], lane_q);
          else
            rsp_rdata <= load_extend(mem_read_data, funct3_q, lane_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_ready && req_valid) begin
      is_store_q <= req_is_store;
      funct3_q   <= req_funct3;
      lane_q     <= req_addr[1:0];
      wdata_q    <= req_wdata[15:0];
    end
  end

endmodule
